// File: rtl/xdma_dsc_byp_ctrl.sv
// XDMA descriptor-bypass controller: splits transfer requests into per-channel
// descriptors of at most MAX_DSC_LEN bytes and drives the XDMA bypass ports.
module xdma_dsc_byp_ctrl #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned MAX_DSC_LEN = 4096,
  parameter int unsigned REQ_LEN_W   = 32
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  // request port
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_ch,
  input  logic [63:0]            req_src_addr,
  input  logic [63:0]            req_dst_addr,
  input  logic [REQ_LEN_W-1:0]   req_len,
  input  logic                   req_irq,
  // descriptor bypass ports, flattened per channel
  output logic [NUM_CH-1:0]      dsc_byp_load,
  input  logic [NUM_CH-1:0]      dsc_byp_ready,
  output logic [NUM_CH*64-1:0]   dsc_byp_src_addr,
  output logic [NUM_CH*64-1:0]   dsc_byp_dst_addr,
  output logic [NUM_CH*28-1:0]   dsc_byp_len,
  output logic [NUM_CH*16-1:0]   dsc_byp_ctl,
  // status
  output logic [NUM_CH-1:0]      ch_busy,
  output logic [NUM_CH*16-1:0]   done_cnt,
  output logic                   req_err
);

  // Length arithmetic is done at least 28 bits wide so MAX_DSC_LEN (up to 2^27)
  // always fits, even for narrow request length fields.
  localparam int unsigned CalcW = (REQ_LEN_W > 28) ? REQ_LEN_W : 28;
  localparam logic [CalcW-1:0] MaxLen = CalcW'(MAX_DSC_LEN);

  typedef enum logic [0:0] {StIdle, StEmit} ch_state_e;

  logic              ch_oob;
  logic              len_zero;
  logic              req_fire;
  logic              req_drop;
  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] ch_idle;
  logic              req_err_q;

  // Out-of-range channels are always ready so the request can be consumed and dropped.
  assign ch_oob   = (32'(req_ch) >= NUM_CH);
  assign len_zero = (req_len == '0);

  // Request handshake: ready when the addressed engine is idle or the index is invalid.
  always_comb begin
    req_ready = ch_oob;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel[i] && ch_idle[i]) begin
        req_ready = 1'b1;
      end
    end
  end

  assign req_fire = req_valid & req_ready;
  assign req_drop = req_fire & (ch_oob | len_zero);

  // Dropped requests are flagged with a single-cycle error pulse.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      req_err_q <= 1'b0;
    end else begin
      req_err_q <= req_drop;
    end
  end

  assign req_err = req_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e            state_q, state_d;
    logic [63:0]          src_q, src_d;
    logic [63:0]          dst_q, dst_d;
    logic [REQ_LEN_W-1:0] rem_q, rem_d;
    logic                 irq_q, irq_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [CalcW-1:0]     rem_ext;
    logic [CalcW-1:0]     cur_ext;
    logic                 last;
    logic                 load;
    logic                 xfer;
    logic                 take;

    assign ch_sel[i] = (32'(req_ch) == i);

    assign rem_ext = CalcW'(rem_q);
    assign last    = (rem_ext <= MaxLen);
    assign cur_ext = last ? rem_ext : MaxLen;
    assign load    = (state_q == StEmit);
    assign xfer    = load & dsc_byp_ready[i];
    // ch_sel only matches in-range channels, so only the zero-length case needs excluding.
    assign take    = req_fire & ch_sel[i] & ~len_zero;

    // Engine next state: latch a request when idle, advance one descriptor per transfer.
    always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      irq_d   = irq_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        StIdle: begin
          if (take) begin
            state_d = StEmit;
            src_d   = req_src_addr;
            dst_d   = req_dst_addr;
            rem_d   = req_len;
            irq_d   = req_irq;
          end
        end
        StEmit: begin
          if (xfer) begin
            // Address wrap past 2^64 is intentional modulo arithmetic.
            src_d = src_q + 64'(cur_ext);
            dst_d = dst_q + 64'(cur_ext);
            rem_d = rem_q - cur_ext[REQ_LEN_W-1:0];
            if (last) begin
              state_d = StIdle;
              cnt_d   = cnt_q + 16'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Engine state registers; reset abandons any descriptors still pending.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
        state_q <= StIdle;
        src_q   <= '0;
        dst_q   <= '0;
        rem_q   <= '0;
        irq_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        src_q   <= src_d;
        dst_q   <= dst_d;
        rem_q   <= rem_d;
        irq_q   <= irq_d;
        cnt_q   <= cnt_d;
      end
    end

    assign ch_idle[i]      = ~load;
    assign ch_busy[i]      = load;
    assign dsc_byp_load[i] = load;

    // Descriptor fields are forced to zero whenever the channel is not loading.
    assign dsc_byp_src_addr[64*i +: 64] = load ? src_q : '0;
    assign dsc_byp_dst_addr[64*i +: 64] = load ? dst_q : '0;
    assign dsc_byp_len[28*i +: 28]      = load ? cur_ext[27:0] : '0;
    // Bit 4 = EOP, bit 1 = completion interrupt; both only on the final descriptor.
    assign dsc_byp_ctl[16*i +: 16]      = load ? {11'd0, last, 2'd0, last & irq_q, 1'b0} : '0;
    assign done_cnt[16*i +: 16]         = cnt_q;
  end

endmodule

// File: tb/tb_xdma_dsc_byp_ctrl.sv
// Self-checking bench for xdma_dsc_byp_ctrl: per-channel descriptor queue model
// compared every cycle, plus directed scenarios with hand-computed literals.
module tb_xdma_dsc_byp_ctrl;

  localparam int unsigned NCH  = 2;
  localparam int unsigned MAXL = 4096;

  typedef struct packed {
    logic [63:0] src;
    logic [63:0] dst;
    logic [27:0] len;
    logic [15:0] ctl;
  } dsc_t;

  typedef struct packed {
    dsc_t d;
    int   cyc;
  } obs_t;

  logic               axi_aclk;
  logic               axi_aresetn;
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_ch;
  logic [63:0]        req_src_addr;
  logic [63:0]        req_dst_addr;
  logic [31:0]        req_len;
  logic               req_irq;
  logic [NCH-1:0]     dsc_byp_load;
  logic [NCH-1:0]     dsc_byp_ready;
  logic [NCH*64-1:0]  dsc_byp_src_addr;
  logic [NCH*64-1:0]  dsc_byp_dst_addr;
  logic [NCH*28-1:0]  dsc_byp_len;
  logic [NCH*16-1:0]  dsc_byp_ctl;
  logic [NCH-1:0]     ch_busy;
  logic [NCH*16-1:0]  done_cnt;
  logic               req_err;

  // Model state: pending descriptors per channel, completion counts, error flag.
  dsc_t        mq [NCH][$];
  obs_t        obs[NCH][$];
  logic [15:0] m_done[NCH];
  logic        m_err;
  int          stall[NCH];
  int          cyc;
  int          checks;
  int          failures;

  xdma_dsc_byp_ctrl #(
    .NUM_CH      (NCH),
    .MAX_DSC_LEN (MAXL),
    .REQ_LEN_W   (32)
  ) u_dut (
    .axi_aclk         (axi_aclk),
    .axi_aresetn      (axi_aresetn),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_ch           (req_ch),
    .req_src_addr     (req_src_addr),
    .req_dst_addr     (req_dst_addr),
    .req_len          (req_len),
    .req_irq          (req_irq),
    .dsc_byp_load     (dsc_byp_load),
    .dsc_byp_ready    (dsc_byp_ready),
    .dsc_byp_src_addr (dsc_byp_src_addr),
    .dsc_byp_dst_addr (dsc_byp_dst_addr),
    .dsc_byp_len      (dsc_byp_len),
    .dsc_byp_ctl      (dsc_byp_ctl),
    .ch_busy          (ch_busy),
    .done_cnt         (done_cnt),
    .req_err          (req_err)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Split a request into the descriptor list it must produce.
  task automatic model_load(input int ch, input logic [63:0] s, input logic [63:0] d,
                            input logic [31:0] l, input logic irq);
    logic [63:0] rem;
    dsc_t        e;
    rem = {32'd0, l};
    while (rem != 64'd0) begin
      e.len = (rem > 64'(MAXL)) ? 28'(MAXL) : rem[27:0];
      e.src = s;
      e.dst = d;
      e.ctl = (rem <= 64'(MAXL)) ? (irq ? 16'h0012 : 16'h0010) : 16'h0000;
      mq[ch].push_back(e);
      s   = s + 64'(e.len);
      d   = d + 64'(e.len);
      rem = rem - 64'(e.len);
    end
  endtask

  // Compare DUT against the model on every falling edge, then advance the model.
  always @(negedge axi_aclk) begin
    dsc_t e;
    obs_t o;
    logic exp_load;
    logic exp_rdy;
    cyc++;
    if (!axi_aresetn) begin
      for (int c = 0; c < NCH; c++) begin
        mq[c].delete();
        m_done[c] = 16'd0;
      end
      m_err = 1'b0;
    end
    for (int c = 0; c < NCH; c++) begin
      exp_load = (mq[c].size() > 0);
      e = exp_load ? mq[c][0] : '0;
      chk($sformatf("load%0d", c), 64'(dsc_byp_load[c]), 64'(exp_load));
      chk($sformatf("busy%0d", c), 64'(ch_busy[c]), 64'(exp_load));
      chk($sformatf("src%0d", c), dsc_byp_src_addr[64*c +: 64], e.src);
      chk($sformatf("dst%0d", c), dsc_byp_dst_addr[64*c +: 64], e.dst);
      chk($sformatf("len%0d", c), 64'(dsc_byp_len[28*c +: 28]), 64'(e.len));
      chk($sformatf("ctl%0d", c), 64'(dsc_byp_ctl[16*c +: 16]), 64'(e.ctl));
      chk($sformatf("done%0d", c), 64'(done_cnt[16*c +: 16]), 64'(m_done[c]));
    end
    if (32'(req_ch) >= NCH) exp_rdy = 1'b1;
    else exp_rdy = (mq[req_ch].size() == 0);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("req_err", 64'(req_err), 64'(m_err));
    if (axi_aresetn) begin
      for (int c = 0; c < NCH; c++) begin
        if (dsc_byp_load[c] && dsc_byp_ready[c]) begin
          o.d.src = dsc_byp_src_addr[64*c +: 64];
          o.d.dst = dsc_byp_dst_addr[64*c +: 64];
          o.d.len = dsc_byp_len[28*c +: 28];
          o.d.ctl = dsc_byp_ctl[16*c +: 16];
          o.cyc   = cyc;
          obs[c].push_back(o);
        end
        if (dsc_byp_load[c] && !dsc_byp_ready[c]) stall[c]++;
      end
      m_err = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (mq[c].size() > 0 && dsc_byp_ready[c]) begin
          e = mq[c].pop_front();
          if (mq[c].size() == 0) m_done[c]++;
        end
      end
      if (req_valid && exp_rdy) begin
        if (32'(req_ch) >= NCH || req_len == 32'd0) m_err = 1'b1;
        else model_load(int'(req_ch), req_src_addr, req_dst_addr, req_len, req_irq);
      end
    end
  end

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic send(input logic [1:0] ch, input logic [63:0] s, input logic [63:0] d,
                      input logic [31:0] l, input logic irq);
    req_valid    = 1'b1;
    req_ch       = ch;
    req_src_addr = s;
    req_dst_addr = d;
    req_len      = l;
    req_irq      = irq;
    tick();
    req_valid    = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (ch_busy != '0 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle", 64'(ch_busy), 64'd0);
  endtask

  task automatic clear_obs();
    for (int c = 0; c < NCH; c++) begin
      obs[c].delete();
      stall[c] = 0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    m_err    = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_done[c] = 16'd0;
      stall[c]  = 0;
    end
    axi_aresetn   = 1'b0;
    req_valid     = 1'b0;
    req_ch        = 2'd0;
    req_src_addr  = 64'd0;
    req_dst_addr  = 64'd0;
    req_len       = 32'd0;
    req_irq       = 1'b0;
    dsc_byp_ready = 2'b11;
    repeat (3) tick();
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_load", 64'(dsc_byp_load), 64'd0);
    chk("rst_done", 64'(done_cnt), 64'd0);
    chk("rst_err", 64'(req_err), 64'd0);
    axi_aresetn = 1'b1;
    tick();

    // Split into three back-to-back descriptors.
    clear_obs();
    send(2'd0, 64'h1000, 64'h8000_0000, 32'd10000, 1'b1);
    wait_idle(20);
    chk("split_n", 64'(obs[0].size()), 64'd3);
    if (obs[0].size() == 3) begin
      chk("split_len0", 64'(obs[0][0].d.len), 64'd4096);
      chk("split_len1", 64'(obs[0][1].d.len), 64'd4096);
      chk("split_len2", 64'(obs[0][2].d.len), 64'd1808);
      chk("split_src0", obs[0][0].d.src, 64'h1000);
      chk("split_src1", obs[0][1].d.src, 64'h2000);
      chk("split_src2", obs[0][2].d.src, 64'h3000);
      chk("split_ctl0", 64'(obs[0][0].d.ctl), 64'h0000);
      chk("split_ctl1", 64'(obs[0][1].d.ctl), 64'h0000);
      chk("split_ctl2", 64'(obs[0][2].d.ctl), 64'h0012);
      chk("split_gap1", 64'(obs[0][1].cyc - obs[0][0].cyc), 64'd1);
      chk("split_gap2", 64'(obs[0][2].cyc - obs[0][1].cyc), 64'd1);
    end
    chk("split_done", 64'(done_cnt[15:0]), 64'd1);

    // Backpressure: one descriptor held for five stalled cycles.
    clear_obs();
    dsc_byp_ready = 2'b10;
    send(2'd0, 64'h4000, 64'h10, 32'd4096, 1'b0);
    repeat (5) tick();
    dsc_byp_ready = 2'b11;
    wait_idle(10);
    chk("bp_stall", 64'(stall[0]), 64'd5);
    chk("bp_n", 64'(obs[0].size()), 64'd1);
    if (obs[0].size() == 1) begin
      chk("bp_len", 64'(obs[0][0].d.len), 64'd4096);
      chk("bp_ctl", 64'(obs[0][0].d.ctl), 64'h0010);
      chk("bp_src", obs[0][0].d.src, 64'h4000);
    end
    chk("bp_done", 64'(done_cnt[15:0]), 64'd2);

    // Concurrency: ch0 stalled while ch1 completes; busy channel refuses requests.
    clear_obs();
    dsc_byp_ready = 2'b10;
    send(2'd0, 64'h10000, 64'h20000, 32'd8192, 1'b0);
    req_ch = 2'd0;
    #1;
    chk("busy_ready", 64'(req_ready), 64'd0);
    send(2'd1, 64'h500, 64'h600, 32'd64, 1'b0);
    repeat (3) tick();
    chk("conc_done1", 64'(done_cnt[31:16]), 64'd1);
    chk("conc_busy", 64'(ch_busy), 64'b01);
    chk("conc_n1", 64'(obs[1].size()), 64'd1);
    if (obs[1].size() == 1) begin
      chk("conc_len1", 64'(obs[1][0].d.len), 64'd64);
      chk("conc_ctl1", 64'(obs[1][0].d.ctl), 64'h0010);
    end
    chk("conc_n0_stalled", 64'(obs[0].size()), 64'd0);
    dsc_byp_ready = 2'b11;
    wait_idle(20);
    chk("conc_n0", 64'(obs[0].size()), 64'd2);
    if (obs[0].size() == 2) begin
      chk("conc_src01", obs[0][1].d.src, 64'h11000);
      chk("conc_ctl01", 64'(obs[0][1].d.ctl), 64'h0010);
    end
    chk("conc_done0", 64'(done_cnt[15:0]), 64'd3);

    // Drops: invalid channel and zero length.
    clear_obs();
    req_valid = 1'b1;
    req_ch    = 2'd3;
    req_len   = 32'd100;
    #1;
    chk("drop_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    chk("drop_err_hi", 64'(req_err), 64'd1);
    chk("drop_load", 64'(dsc_byp_load), 64'd0);
    tick();
    chk("drop_err_lo", 64'(req_err), 64'd0);
    send(2'd1, 64'h700, 64'h800, 32'd0, 1'b1);
    chk("zlen_err_hi", 64'(req_err), 64'd1);
    chk("zlen_load", 64'(dsc_byp_load), 64'd0);
    tick();
    chk("zlen_err_lo", 64'(req_err), 64'd0);
    chk("drop_done", 64'(done_cnt), 64'h0001_0003);

    // Address wrap at 2^64.
    clear_obs();
    send(2'd1, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 32'd8192, 1'b1);
    wait_idle(20);
    chk("wrap_n", 64'(obs[1].size()), 64'd2);
    if (obs[1].size() == 2) begin
      chk("wrap_src0", obs[1][0].d.src, 64'hFFFF_FFFF_FFFF_F000);
      chk("wrap_src1", obs[1][1].d.src, 64'h0);
      chk("wrap_dst1", obs[1][1].d.dst, 64'h3000);
      chk("wrap_ctl1", 64'(obs[1][1].d.ctl), 64'h0012);
    end
    chk("wrap_done1", 64'(done_cnt[31:16]), 64'd2);

    // Reset mid-request abandons remaining descriptors.
    dsc_byp_ready = 2'b00;
    send(2'd0, 64'h9000, 64'hA000, 32'd16384, 1'b1);
    tick();
    axi_aresetn = 1'b0;
    #2;
    chk("mrst_load", 64'(dsc_byp_load), 64'd0);
    chk("mrst_busy", 64'(ch_busy), 64'd0);
    chk("mrst_done", 64'(done_cnt), 64'd0);
    chk("mrst_ready", 64'(req_ready), 64'd1);
    chk("mrst_src", dsc_byp_src_addr[63:0], 64'd0);
    chk("mrst_len", 64'(dsc_byp_len), 64'd0);
    tick();
    tick();
    axi_aresetn   = 1'b1;
    dsc_byp_ready = 2'b11;
    clear_obs();
    repeat (10) tick();
    chk("mrst_after_n", 64'(obs[0].size()), 64'd0);
    chk("mrst_after_busy", 64'(ch_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/xdma_dsc_byp_ctrl.md
XDMA_DSC_BYP_CTRL -- requirements
Module: xdma_dsc_byp_ctrl

Interface
REQ-001 Parameter NUM_CH, default 2: number of XDMA descriptor-bypass channels driven, legal range 1..4.
REQ-002 Parameter MAX_DSC_LEN, default 4096: maximum bytes per descriptor, a power of two in the range 64..2^27.
REQ-003 Parameter REQ_LEN_W, default 32: width of the request length field in bytes.
REQ-004 The block SHALL have one clock and one reset: reset is asynchronous and active-low; ports axi_aclk and axi_aresetn.
REQ-005 axi_aclk  in  1  block clock.
REQ-006 axi_aresetn  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  transfer request valid.
REQ-008 req_ready  out  1  request accepted on the cycle where req_valid and req_ready are both 1.
REQ-009 req_ch  in  2  target channel index.
REQ-010 req_src_addr  in  64  source byte address.
REQ-011 req_dst_addr  in  64  destination byte address.
REQ-012 req_len  in  REQ_LEN_W  total transfer length in bytes.
REQ-013 req_irq  in  1  request a completion interrupt on the last descriptor.
REQ-014 dsc_byp_load  out  NUM_CH  per-channel descriptor valid.
REQ-015 dsc_byp_ready  in  NUM_CH  per-channel XDMA bypass ready.
REQ-016 dsc_byp_src_addr  out  NUM_CH*64  flattened per-channel source address; channel i occupies bits [64i+63:64i].
REQ-017 dsc_byp_dst_addr  out  NUM_CH*64  flattened per-channel destination address, using the same slicing as REQ-016.
REQ-018 dsc_byp_len  out  NUM_CH*28  flattened per-channel descriptor length.
REQ-019 dsc_byp_ctl  out  NUM_CH*16  flattened per-channel descriptor control.
REQ-020 ch_busy  out  NUM_CH  channel engine is not idle.
REQ-021 done_cnt  out  NUM_CH*16  per-channel count of completed requests.
REQ-022 req_err  out  1  one-cycle pulse when a request is dropped.

Function
REQ-023 Each channel SHALL have an independent engine with two states, IDLE and EMIT.
REQ-024 req_ready SHALL be 1 exactly when either req_ch < NUM_CH and that channel's engine is IDLE, or req_ch >= NUM_CH.
REQ-025 An accepted request with req_ch >= NUM_CH, or with req_len == 0, SHALL be dropped.
- No engine changes state.
- req_err pulses high on the next cycle.
REQ-026 Any other accepted request SHALL latch src, dst, remaining = req_len and irq into its channel, and move that channel IDLE -> EMIT on the next edge.
REQ-027 In EMIT, the channel drives dsc_byp_load = 1 with cur_len = min(remaining, MAX_DSC_LEN).
REQ-028 In EMIT, the descriptor fields SHALL stay stable until the channel's dsc_byp_ready is sampled 1.
REQ-029 A descriptor SHALL transfer on each cycle where dsc_byp_load and dsc_byp_ready are both 1 for that channel.
REQ-030 On each transfer the engine SHALL update its state as follows.
- src += cur_len.
- dst += cur_len.
- remaining -= cur_len.
- The next descriptor may be driven on the following cycle.
REQ-031 Gaps between descriptors SHALL be caused only by ready.
REQ-032 dsc_byp_ctl SHALL be built as follows.
- Bit 4 (EOP) is 1 only on the last descriptor (remaining <= MAX_DSC_LEN).
- Bit 1 (completed/interrupt) is 1 only on the last descriptor and only when the latched irq == 1.
- All other bits are 0.
REQ-033 On transfer of the last descriptor, the engine SHALL return to IDLE and increment done_cnt of that channel by 1.
- done_cnt wraps from 0xFFFF to 0.
REQ-034 The channel SHALL be able to accept a new request on the cycle after it returns to IDLE.
REQ-035 Address arithmetic SHALL be 64-bit modulo 2^64; a wrap-around is not an error.
REQ-036 Length output SHALL be cur_len zero-extended to 28 bits.
REQ-037 When no descriptor is loading on a channel, its dsc_byp fields SHALL be driven to 0.
REQ-038 Channels SHALL operate concurrently; a stall on one channel SHALL NOT affect the others.
REQ-039 ch_busy[i] SHALL be 1 exactly when channel i is in EMIT.

Reset
REQ-040 While axi_aresetn = 0, the block SHALL be reset asynchronously as follows.
- All engines go to IDLE.
- dsc_byp_load = 0, all dsc fields = 0, ch_busy = 0, done_cnt = 0, req_err = 0.
- req_ready follows REQ-024, so it is 1.
REQ-041 A reset asserted mid-transfer SHALL abandon the remaining descriptors; after release, no descriptor of the abandoned request is emitted.

Verification
REQ-042 Split: ch0, src 0x1000, dst 0x8000_0000, len 10000, irq 1, MAX 4096, ready held 1 -> three descriptors on consecutive cycles.
- Lengths 4096, 4096, 1808.
- src 0x1000, 0x2000, 0x3000.
- ctl 0x0000, 0x0000, 0x0012.
- done_cnt[0] = 1.
REQ-043 Backpressure: len 4096, dsc_byp_ready low for 5 cycles -> a single descriptor held stable for 5 cycles, then transferred; ctl 0x0010 (irq 0).
REQ-044 Concurrency: ch0 len 8192 with ready 0 and ch1 len 64 with ready 1 -> ch1 descriptor is issued and done_cnt[1] = 1 while ch0 stays busy; after ch0 is released, ch0 emits 2 descriptors.
REQ-045 Drop: req_ch = 3 with NUM_CH = 2, or len 0 -> request accepted, req_err pulses for 1 cycle, no load is asserted, done_cnt is unchanged.
REQ-046 Busy / wrap / reset checks:
- A second request to a busy channel sees req_ready = 0.
- src 0xFFFF_FFFF_FFFF_F000 with len 8192 -> second descriptor src = 0.
- axi_aresetn pulsed low mid-request -> all outputs read 0 and the channel is IDLE.
